lisnoc_packet_tx: RTL and testbench

- Local-port packet injector. Converts a processing element's send request (destination, length, payload words) into a LISNoC flit stream.
- Drives the router's local input link (flit, per-vchannel valid, per-vchannel ready).
- Inserts the header flit, tags every flit with its type, and holds each flit on the link until the router accepts it.
- One packet in flight at a time; packets are never interleaved.

---
 rtl/lisnoc_packet_tx.sv | 91 +++++++++
 tb/tb_lisnoc_packet_tx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lisnoc_packet_tx.sv
// lisnoc_packet_tx: turns PE send requests into a LISNoC flit stream on the local link
module lisnoc_packet_tx #(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int destwidth = 5,
    parameter int vchannels = 1,
    parameter int len_width = 8,
    localparam int vc_width = vchannels > 1 ? $clog2(vchannels) : 1,
    localparam int flit_width = flit_data_width + flit_type_width
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [destwidth-1:0]       req_dest_i,
    input  logic [len_width-1:0]       req_len_i,
    input  logic [vc_width-1:0]        req_vc_i,
    input  logic [flit_data_width-1:0] data_i,
    input  logic                       data_valid_i,
    output logic                       data_ready_o,
    output logic [flit_width-1:0]      link_flit_o,
    output logic [vchannels-1:0]       link_valid_o,
    input  logic [vchannels-1:0]       link_ready_i,
    output logic                       busy_o
);
    localparam logic [flit_type_width-1:0] t_payload = flit_type_width'(0);
    localparam logic [flit_type_width-1:0] t_header  = flit_type_width'(1);
    localparam logic [flit_type_width-1:0] t_last    = flit_type_width'(2);
    localparam logic [flit_type_width-1:0] t_single  = flit_type_width'(3);

    typedef enum logic {idle, payload} state_t;

    state_t                     state, state_nxt;
    logic [flit_width-1:0]      out_flit, flit_nxt;
    logic                       out_valid;
    logic [vc_width-1:0]        out_vc;
    logic [len_width-1:0]       remain;
    logic [flit_data_width-1:0] hdr;
    logic                       xfer, free, req_acc, data_acc;

    assign link_flit_o = out_flit;
    assign busy_o = state != idle || out_valid;

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= idle;
        else state <= state_nxt;

    // next state: a zero-length request never leaves idle, the LAST word returns to it
    always_comb
        state_nxt = state == idle ? (req_acc && req_len_i != '0 ? payload : idle)
                                  : (data_acc && remain == len_width'(1) ? idle : payload);

    // handshakes, link valid and the flit that would be loaded this cycle
    always_comb begin
        link_valid_o = vchannels'(out_valid) << out_vc;
        xfer = |(link_valid_o & link_ready_i);
        free = !out_valid || xfer;
        req_ready_o = state == idle && free;
        data_ready_o = state == payload && free;
        req_acc = req_valid_i && req_ready_o;
        data_acc = data_valid_i && data_ready_o;
        hdr = '0;
        hdr[flit_data_width-1 -: destwidth] = req_dest_i;
        hdr[len_width-1:0] = req_len_i;
        flit_nxt = req_acc ? {req_len_i == '0 ? t_single : t_header, hdr}
                           : {remain == len_width'(1) ? t_last : t_payload, data_i};
    end

    // output register and remaining-word counter; the register holds while stalled
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            out_flit <= '0;
            out_valid <= 1'b0;
            out_vc <= '0;
            remain <= '0;
        end else begin
            if (req_acc) begin
                out_vc <= req_vc_i;
                remain <= req_len_i;
            end else if (data_acc) begin
                remain <= remain - len_width'(1);
            end
            if (req_acc || data_acc) begin
                out_flit <= flit_nxt;
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_lisnoc_packet_tx.sv
// tb_lisnoc_packet_tx: randomized bench against a queue-based model of the flit stream
module tb_lisnoc_packet_tx;
    localparam int FDW = 32, DW = 5, VCH = 2, LW = 8, FW = FDW + 2;

    logic           clk = 0, rst = 1;
    logic           req_valid_i = 0, req_ready_o;
    logic [DW-1:0]  req_dest_i = '0;
    logic [LW-1:0]  req_len_i = '0;
    logic [0:0]     req_vc_i = '0;
    logic [FDW-1:0] data_i = '0;
    logic           data_valid_i = 0, data_ready_o;
    logic [FW-1:0]  link_flit_o;
    logic [VCH-1:0] link_valid_o, link_ready_i = '0;
    logic           busy_o;

    int total = 0, bad = 0, cyc = 0, rem = 0;
    logic [0:0] cur_vc = '0;
    logic [FW:0] q[$];
    int p_ready = 100, ready_mode = 0, p_dv = 100, p_rv = 100, lmax = 6;
    int force_len = -1, force_vc = -1, force_dest = -1;

    lisnoc_packet_tx #(.vchannels(VCH)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_dest_i(req_dest_i), .req_len_i(req_len_i), .req_vc_i(req_vc_i),
        .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
        .link_flit_o(link_flit_o), .link_valid_o(link_valid_o), .link_ready_i(link_ready_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // one clock: drive at negedge, compare against model, advance model over the posedge
    task automatic step();
        logic [FW:0] h;
        logic [VCH-1:0] ev;
        logic fr, xf;
        logic [FDW-1:0] hdr;
        for (int v = 0; v < VCH; v++) link_ready_i[v] = $urandom_range(99) < p_ready;
        if (ready_mode == 1) link_ready_i = (cyc % 3 == 0) ? '1 : '0;
        if (ready_mode == 2) link_ready_i[0] = 1'b0;
        data_valid_i = $urandom_range(99) < p_dv;
        data_i = $urandom;
        req_valid_i = $urandom_range(99) < p_rv;
        req_dest_i = force_dest >= 0 ? DW'(force_dest) : DW'($urandom);
        req_len_i = force_len >= 0 ? LW'(force_len) : LW'($urandom_range(lmax));
        req_vc_i = force_vc >= 0 ? 1'(force_vc) : 1'($urandom_range(1));
        #1;
        h = q.size() > 0 ? q[0] : '0;
        ev = q.size() > 0 ? VCH'(1) << h[FW] : '0;
        xf = q.size() > 0 && link_ready_i[h[FW]];
        fr = q.size() == 0 || xf;
        check("link_valid", link_valid_o, ev);
        if (q.size() > 0) check("link_flit", link_flit_o, h[FW-1:0]);
        check("req_ready", req_ready_o, rem == 0 && fr);
        check("data_ready", data_ready_o, rem > 0 && fr);
        check("busy", busy_o, rem > 0 || q.size() > 0);
        if (xf) void'(q.pop_front());
        if (req_valid_i && rem == 0 && fr) begin
            hdr = (FDW'(req_dest_i) << (FDW - DW)) + FDW'(req_len_i);
            cur_vc = req_vc_i;
            q.push_back({cur_vc, req_len_i == 0 ? 2'b11 : 2'b01, hdr});
            rem = req_len_i;
        end else if (data_valid_i && rem > 0 && fr) begin
            q.push_back({cur_vc, rem == 1 ? 2'b10 : 2'b00, data_i});
            rem--;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_packet();
        int n;
        p_rv = 100;
        n = 0;
        while (rem == 0 && q.size() == 0 && n < 50) begin step(); n++; end
        check("accept_timeout", n < 50, 1);
        p_rv = 0;
        n = 0;
        while ((rem > 0 || q.size() > 0) && n < 3000) begin step(); n++; end
        check("drain_timeout", n < 3000, 1);
    endtask

    initial begin
        int n;
        #2;
        check("rst_valid", link_valid_o, 0);
        check("rst_flit", link_flit_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_req_ready", req_ready_o, 1);
        check("rst_data_ready", data_ready_o, 0);
        @(negedge clk);
        rst = 0;
        force_dest = 5; force_len = 0; force_vc = 0;
        step();
        check("single_flit", link_flit_o, {2'b11, 32'h2800_0000});
        p_rv = 0;
        repeat (3) step();
        force_dest = 3; force_len = 3; p_rv = 100;
        step();
        check("hdr_flit", link_flit_o, {2'b01, 32'h1800_0003});
        p_rv = 0;
        repeat (6) step();
        force_dest = -1;
        ready_mode = 1;
        run_packet();
        ready_mode = 2; force_vc = 1; force_len = 5; p_ready = 60;
        run_packet();
        run_packet();
        ready_mode = 0; force_vc = -1; force_len = 255; p_ready = 100;
        run_packet();
        p_ready = 60; p_dv = 80;
        run_packet();
        force_len = -1; p_ready = 70; p_dv = 70; p_rv = 50;
        repeat (400) step();
        p_rv = 0;
        n = 0;
        while ((rem > 0 || q.size() > 0) && n < 500) begin step(); n++; end
        check("final_drain", n < 500, 1);
        force_len = 4; p_ready = 100; p_dv = 100; p_rv = 100;
        n = 0;
        while (!(rem == 2) && n < 20) begin step(); n++; end
        check("reach_mid_packet", rem, 2);
        req_valid_i = 0;
        #2 rst = 1;
        #1;
        check("arst_valid", link_valid_o, 0);
        check("arst_flit", link_flit_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_req_ready", req_ready_o, 1);
        check("arst_data_ready", data_ready_o, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        q.delete();
        rem = 0;
        force_len = 1;
        run_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
